// File: rtl/fir_stream_scheduler.sv
// fir_stream_scheduler: sample FIFO, engine pacing and result capture
// for the moving-average FIR engine, with warm-up tracking and flush.
module fir_stream_scheduler #(
  parameter int DATA_WIDTH      = 16,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int FILTER_LATENCY  = 6,
  parameter int TAPS            = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  flush,
  output logic                  flt_rst,
  output logic                  flt_sample_valid,
  output logic [DATA_WIDTH-1:0] flt_data,
  input  logic [DATA_WIDTH-1:0] flt_lp,
  input  logic [DATA_WIDTH-1:0] flt_hp,
  input  logic [DATA_WIDTH-1:0] flt_ref,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_lp,
  output logic [DATA_WIDTH-1:0] out_hp,
  output logic [DATA_WIDTH-1:0] out_ref,
  output logic                  out_warm,
  output logic                  busy
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int WW    = $clog2(TAPS + 1);
  localparam int CW    = $clog2(FILTER_LATENCY + 1);

  localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(DEPTH);
  localparam logic [WW-1:0] TAPS_C   = WW'(TAPS);
  localparam logic [CW-1:0] CNT_INIT = CW'(FILTER_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    CAPTURE,
    FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  flush_pend_q, flush_pend_d;
  logic [WW-1:0]         warm_cnt_q, warm_cnt_d;
  logic [WW:0]           warm_inc;

  logic                  fsv_q, fsv_d;
  logic [DATA_WIDTH-1:0] flt_data_q, flt_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_lp_q, out_lp_d;
  logic [DATA_WIDTH-1:0] out_hp_q, out_hp_d;
  logic [DATA_WIDTH-1:0] out_ref_q, out_ref_d;
  logic                  out_warm_q, out_warm_d;

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign in_ready = !full && !flush_pend_q && (state_q != FLUSH);
  assign push     = in_valid && in_ready;
  assign warm_inc = {1'b0, warm_cnt_q} + 1'b1;

  assign flt_rst          = rst | (state_q == FLUSH);
  assign flt_sample_valid = fsv_q;
  assign flt_data         = flt_data_q;
  assign out_valid        = out_valid_q;
  assign out_lp           = out_lp_q;
  assign out_hp           = out_hp_q;
  assign out_ref          = out_ref_q;
  assign out_warm         = out_warm_q;
  assign busy             = (state_q != IDLE) || !empty;

  // Next-state: FIFO push/pop, engine pacing, capture and flush.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    mem_d        = mem_q;
    flush_pend_d = flush_pend_q | flush;
    warm_cnt_d   = warm_cnt_q;
    fsv_d        = 1'b0;
    flt_data_d   = flt_data_q;
    out_valid_d  = 1'b0;
    out_lp_d     = out_lp_q;
    out_hp_d     = out_hp_q;
    out_ref_d    = out_ref_q;
    out_warm_d   = out_warm_q;
    pop          = 1'b0;

    if (push) begin
      mem_d[wptr_q] = in_data;
      wptr_d        = wptr_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (flush_pend_q) begin
          state_d = FLUSH;
        end else if (!empty) begin
          pop        = 1'b1;
          flt_data_d = mem_q[rptr_q];
          rptr_d     = rptr_q + 1'b1;
          fsv_d      = 1'b1;
          cnt_d      = CNT_INIT;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CAPTURE: begin
        out_lp_d  = flt_lp;
        out_hp_d  = flt_hp;
        out_ref_d = flt_ref;
        if (!flush_pend_q) begin
          out_valid_d = 1'b1;
          out_warm_d  = (warm_inc >= {1'b0, TAPS_C});
          if (warm_cnt_q != TAPS_C) begin
            warm_cnt_d = warm_inc[WW-1:0];
          end
        end
        state_d = IDLE;
      end
      FLUSH: begin
        wptr_d       = '0;
        rptr_d       = '0;
        warm_cnt_d   = '0;
        flush_pend_d = flush;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q == FLUSH) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
      warm_cnt_q   <= '0;
      fsv_q        <= 1'b0;
      flt_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_lp_q     <= '0;
      out_hp_q     <= '0;
      out_ref_q    <= '0;
      out_warm_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      flush_pend_q <= flush_pend_d;
      warm_cnt_q   <= warm_cnt_d;
      fsv_q        <= fsv_d;
      flt_data_q   <= flt_data_d;
      out_valid_q  <= out_valid_d;
      out_lp_q     <= out_lp_d;
      out_hp_q     <= out_hp_d;
      out_ref_q    <= out_ref_d;
      out_warm_q   <= out_warm_d;
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: doc/fir_stream_scheduler.md
# fir_stream_scheduler

Sequencing front-end for the single-stream moving-average FIR engine (128-tap low-pass, high-pass, delayed-reference outputs).
- Accepts input samples on a valid/ready handshake and buffers them in a small FIFO.
- Issues `sample_valid` pulses to the engine no faster than its fixed processing time, then captures the three engine results and presents them as one tagged output beat.
- Tracks window fill (warm-up) and performs controlled flushes by resetting the engine.
- Sits between the sample source (ADC/deserializer) and downstream consumers of the filter outputs.

## Interface
- DATA_WIDTH, 16, sample and result width (two's complement)
- FIFO_DEPTH_LOG2, 2, input FIFO holds 2^FIFO_DEPTH_LOG2 samples
- FILTER_LATENCY, 6, cycles from engine sampling `sample_valid` until its outputs are updated and it can take the next sample
- TAPS, 128, window length; results count as warm once TAPS samples are processed
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample offered
- in_ready  out  1  FIFO can accept (combinational)
- in_data  in  DATA_WIDTH  input sample
- flush  in  1  single-cycle request to clear FIFO, window and engine state
- flt_rst  out  1  engine reset
- flt_sample_valid  out  1  engine sample strobe (registered, one-cycle pulse)
- flt_data  out  DATA_WIDTH  engine sample (registered)
- flt_lp, flt_hp, flt_ref  in  DATA_WIDTH each  engine low-pass, high-pass, delayed-reference outputs
- out_valid  out  1  one-cycle result strobe
- out_lp, out_hp, out_ref  out  DATA_WIDTH each  captured results
- out_warm  out  1  result produced with a full window
- busy  out  1  high when not in IDLE or when the FIFO is non-empty

## Operation
- **FIFO:**
  - Push when `in_valid && in_ready`.
  - `in_ready = !full && !flush_pend && state != FLUSH`.
  - No push while full, even if a pop happens in the same cycle.
  - Pointers wrap modulo depth.
- **State machine IDLE / BUSY / CAPTURE / FLUSH:**
  - IDLE:
    - If `flush_pend`, go to FLUSH.
    - Else if the FIFO is non-empty: pop the head into `flt_data`, set `flt_sample_valid <= 1`, load `cnt <= FILTER_LATENCY-1`, go to BUSY.
    - Else stay in IDLE.
  - BUSY: `flt_sample_valid <= 0`. Decrement `cnt`; when `cnt == 0`, go to CAPTURE.
  - CAPTURE:
    - Register `flt_lp/hp/ref` into `out_*`.
    - If `flush_pend` is clear: `out_valid <= 1`, `warm_cnt` increments saturating at TAPS, `out_warm <= (warm_cnt + 1 >= TAPS)`.
    - If `flush_pend` is set: result discarded, `out_valid` stays 0.
    - Go to IDLE.
  - FLUSH (exactly one cycle):
    - `flt_rst` high.
    - FIFO emptied, `warm_cnt <= 0`, `flush_pend <= 0`.
    - Go to IDLE.
- **flush behaviour:**
  - `flush` sets `flush_pend` in any state.
  - An in-flight sample completes its timing, but its result is dropped.
  - Queued samples are discarded.
- **Engine reset:** `flt_rst = rst | (state == FLUSH)`.
- **Width rules:**
  - `out_*` are copies of the engine values, with no arithmetic applied.
  - `warm_cnt` is `$clog2(TAPS+1)` bits.

## Timing
- Reset values:
  - All registered outputs 0, state IDLE, FIFO empty, `warm_cnt` 0, `flush_pend` 0.
  - `in_ready` is 1 in the cycle after `rst` is released.
  - `flt_rst` is 1 while `rst` is high.
- Sample path, with `flt_sample_valid` high in cycle T:
  - Engine outputs are sampled at the edge ending cycle T+FILTER_LATENCY.
  - `out_valid` is high in cycle T+FILTER_LATENCY+1.
  - The next `flt_sample_valid` is no earlier than cycle T+FILTER_LATENCY+2.
- Latency and throughput:
  - Minimum latency is FILTER_LATENCY+2 cycles from the push edge to `out_valid` (empty FIFO, IDLE).
  - Throughput is 1 sample per FILTER_LATENCY+2 cycles.
- Priority and ordering:
  - Flush has priority over issuing in IDLE.
  - `rst` has priority over everything and aborts mid-operation, with no `out_valid` afterward.
- Simultaneous events:
  - Push in the same cycle as a pop from a non-full FIFO: both occur.
  - `flush` in the same cycle as a push: the push is accepted only if `in_ready` was already 1, and is then discarded by the FLUSH.

## Test plan
- **Single sample:** push 0x0100 into an idle block.
  - `flt_sample_valid` is high 1 cycle later with `flt_data` = 0x0100.
  - `out_valid` is high exactly 7 cycles after that (default latency), and `out_lp` equals the engine's `flt_lp`.
- **Burst with backpressure:** hold `in_valid` with samples 1..8.
  - `in_ready` drops after 4 samples are buffered plus 1 issued.
  - All 8 results appear in order, spaced 8 cycles apart, and none are lost.
- **Warm-up (TAPS=4):** push 6 samples.
  - `out_warm` is 0 for results 1–3 and 1 for results 4–6.
- **Flush while busy:**
  - Setup: 3 samples queued; assert `flush` during BUSY of the first.
  - No `out_valid` for any of the 3 samples.
  - `flt_rst` pulses for exactly 1 cycle after the first sample's CAPTURE.
  - Warm count restarts: with TAPS=4, the next 3 results have `out_warm` = 0.
- **Reset mid-operation:** assert `rst` during CAPTURE.
  - All outputs are 0 and `flt_rst` is 1 while `rst` is high.
  - There is no stale `out_valid`, and a new sample afterwards completes normally.
- **Simultaneous push and pop:** 1 sample queued, push at the same edge IDLE pops.
  - FIFO occupancy stays 1, and the second result follows 8 cycles after the first.
